// File: rtl/lenet_layer_scheduler_if.sv
// rtl/lenet_layer_scheduler_if.sv - handshake bundle between the layer scheduler and its host/layers
interface lenet_layer_scheduler_if #(
    parameter int NUM_LAYERS = 6,
    parameter int GRAPH_W    = 5
);
    logic                  start;
    logic [GRAPH_W-1:0]    num_graphs;
    logic [NUM_LAYERS-1:0] layer_finish;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [GRAPH_W-1:0]    graph;
    logic                  busy;
    logic                  done;
    logic [2:0]            layer_idx;
    logic                  error;

    // Host and layer datapaths: issue batch requests and report layer completion.
    modport master (
        output start, num_graphs, layer_finish,
        input  layer_en, graph, busy, done, layer_idx, error
    );

    // Scheduler side.
    modport slave (
        input  start, num_graphs, layer_finish,
        output layer_en, graph, busy, done, layer_idx, error
    );
endinterface

// File: rtl/lenet_layer_scheduler.sv
// rtl/lenet_layer_scheduler.sv - sequences LeNet layers per image over a batch; optional watchdog via LAYER_TIMEOUT_EN
module lenet_layer_scheduler #(
    parameter int NUM_LAYERS     = 6,
    parameter int GRAPH_W        = 5,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  rst,
    lenet_layer_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [NUM_LAYERS-1:0] EN_FIRST = {{(NUM_LAYERS-1){1'b0}}, 1'b1};
    localparam logic [2:0]            LAST_IDX = 3'(NUM_LAYERS - 1);

    state_t                state;
    logic [NUM_LAYERS-1:0] layer_en_q;
    logic [GRAPH_W-1:0]    graph_q;
    logic [GRAPH_W-1:0]    num_lat;
    logic [2:0]            idx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    // Low on the first cycle of each enable window so a stale finish is not taken as completion.
    logic                  armed;
    logic                  wd_expired;

`ifdef LAYER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts cycles spent in S_RUN; any other state zeroes it, so each S_RUN entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: S_RUN waits indefinitely; the limit parameter stays for a uniform interface.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expired     = 1'b0;
`endif

    // Batch sequencer: one enable window per layer, a one-cycle gap between windows, image stepping after the last layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            layer_en_q <= '0;
            graph_q    <= '0;
            num_lat    <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.num_graphs != '0) begin
                            num_lat    <= bus.num_graphs;
                            graph_q    <= '0;
                            idx_q      <= '0;
                            layer_en_q <= EN_FIRST;
                            armed      <= 1'b0;
                            state      <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    armed <= 1'b1;
                    if (armed && bus.layer_finish[idx_q]) begin
                        layer_en_q <= '0;
                        state      <= S_GAP;
                    end else if (wd_expired) begin
                        layer_en_q <= '0;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= S_ERROR;
                    end
                end
                S_GAP: begin
                    if (idx_q == LAST_IDX) begin
                        state <= S_NEXT;
                    end else begin
                        idx_q      <= idx_q + 3'd1;
                        layer_en_q <= EN_FIRST << (idx_q + 3'd1);
                        armed      <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_NEXT: begin
                    if (graph_q == num_lat - GRAPH_W'(1)) begin
                        state <= S_DONE;
                    end else begin
                        graph_q    <= graph_q + GRAPH_W'(1);
                        idx_q      <= '0;
                        layer_en_q <= EN_FIRST;
                        armed      <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.layer_en  = layer_en_q;
    assign bus.graph     = graph_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.layer_idx = idx_q;
`ifdef LAYER_TIMEOUT_EN
    assign bus.error     = error_q;
`else
    assign bus.error     = 1'b0;
`endif
endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// tb/tb_lenet_layer_scheduler.sv - randomized self-checking bench for lenet_layer_scheduler
module tb_lenet_layer_scheduler;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_g = 0;
    int   last_i = 0;

    logic [5:0] x_en    [MAXC];
    logic [4:0] x_graph [MAXC];
    logic [2:0] x_idx   [MAXC];
    logic       x_busy  [MAXC];
    logic       x_done  [MAXC];
    logic [5:0] fin_drv [MAXC];
    logic       st_drv  [MAXC];
    logic [4:0] ng_drv  [MAXC];

    lenet_layer_scheduler_if #(.NUM_LAYERS(6), .GRAPH_W(5)) bus ();

    lenet_layer_scheduler #(
        .NUM_LAYERS(6),
        .GRAPH_W(5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_all(input int t);
        chk("layer_en", t, 8'(bus.layer_en), 8'(x_en[t]));
        chk("graph", t, 8'(bus.graph), 8'(x_graph[t]));
        chk("layer_idx", t, 8'(bus.layer_idx), 8'(x_idx[t]));
        chk("busy", t, 8'(bus.busy), 8'(x_busy[t]));
        chk("done", t, 8'(bus.done), 8'(x_done[t]));
        chk("error", t, 8'(bus.error), 8'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 0, 8'(bus.layer_en), 8'd0);
        chk({tag, "_graph"}, 0, 8'(bus.graph), 8'd0);
        chk({tag, "_idx"}, 0, 8'(bus.layer_idx), 8'd0);
        chk({tag, "_busy"}, 0, 8'(bus.busy), 8'd0);
        chk({tag, "_done"}, 0, 8'(bus.done), 8'd0);
        chk({tag, "_error"}, 0, 8'(bus.error), 8'd0);
    endtask

    // Builds the expected timeline of a batch from its layer/image plan, then plays it cycle by cycle.
    // Cycle 0 carries the start request; each enable window lasts from its first cycle to the cycle
    // its finish is driven, followed by one gap cycle (two when stepping to the next image).
    task automatic batch(input int n, input bit noise, input bit do_abort);
        int c, e, d, nxt, last, stop_at;
        logic [5:0] one;
        for (int t = 0; t < MAXC; t++) begin
            x_en[t] = '0; x_graph[t] = 5'(last_g); x_idx[t] = 3'(last_i);
            x_busy[t] = 1'b0; x_done[t] = 1'b0;
            fin_drv[t] = '0; st_drv[t] = 1'b0; ng_drv[t] = 5'($urandom);
        end
        st_drv[0] = 1'b1;
        ng_drv[0] = 5'(n);
        stop_at = -1;
        if (n == 0) begin
            x_busy[1] = 1'b1;
            x_done[2] = 1'b1;
            last = 5;
        end else begin
            c = 1;
            for (int g = 0; g < n; g++) begin
                for (int l = 0; l < 6; l++) begin
                    one = 6'd1 << l;
                    d = $urandom_range(1, 12);
                    e = c + d;
                    for (int t = c; t <= e; t++) begin
                        x_en[t] = one; x_graph[t] = 5'(g); x_idx[t] = 3'(l); x_busy[t] = 1'b1;
                        if (noise) fin_drv[t] = 6'($urandom) & ~one;
                    end
                    if (noise && $urandom_range(0, 1) == 1) fin_drv[c] = fin_drv[c] | one;
                    fin_drv[e] = fin_drv[e] | one;
                    if (do_abort && g == 1 && l == 2) stop_at = c + 1;
                    nxt = (l < 5) ? e + 2 : ((g < n - 1) ? e + 3 : e + 4);
                    for (int t = e + 1; t < nxt; t++) begin
                        x_graph[t] = 5'(g); x_idx[t] = 3'(l); x_busy[t] = 1'b1;
                    end
                    c = nxt;
                end
            end
            for (int t = c; t < MAXC; t++) begin
                x_graph[t] = 5'(n - 1); x_idx[t] = 3'd5;
            end
            x_done[c] = 1'b1;
            last = c + 3;
            if (noise) begin
                d = $urandom_range(2, c - 1);
                st_drv[d] = 1'b1;
                ng_drv[d] = 5'($urandom_range(1, 31));
            end
        end

        for (int t = 0; t <= last; t++) begin
            if (t > 0) chk_all(t);
            if (t == stop_at) begin
                bus.start = 1'b0;
                bus.layer_finish = '0;
                rst = 1'b1;
                #1;
                chk_zero("async_rst");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("rst_hold_done", k, 8'(bus.done), 8'd0);
                    chk("rst_hold_en", k, 8'(bus.layer_en), 8'd0);
                end
                rst = 1'b0;
                last_g = 0;
                last_i = 0;
                return;
            end
            bus.start = st_drv[t];
            bus.num_graphs = ng_drv[t];
            bus.layer_finish = fin_drv[t];
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.layer_finish = '0;
        if (n != 0) begin
            last_g = n - 1;
            last_i = 5;
        end
    endtask

`ifdef LAYER_TIMEOUT_EN
    // Layer 2 of image 0 never reports finish; the watchdog must trip after 50 enabled cycles.
    task automatic timeout_test();
        bus.start = 1'b1;
        bus.num_graphs = 5'd2;
        bus.layer_finish = '0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 1; t <= 90; t++) begin
            if (t == 11) chk("to_en2", t, 8'(bus.layer_en), 8'h04);
            if (t == 60) begin
                chk("to_en_last", t, 8'(bus.layer_en), 8'h04);
                chk("to_busy_last", t, 8'(bus.busy), 8'd1);
            end
            if (t == 61 || t == 90) begin
                chk("to_en", t, 8'(bus.layer_en), 8'd0);
                chk("to_error", t, 8'(bus.error), 8'd1);
                chk("to_idx", t, 8'(bus.layer_idx), 8'd2);
                chk("to_graph", t, 8'(bus.graph), 8'd0);
                chk("to_busy", t, 8'(bus.busy), 8'd0);
            end
            bus.layer_finish = (t == 4) ? 6'h01 : ((t == 9) ? 6'h02 : 6'h00);
            bus.start = (t == 70);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("to_rst");
        @(negedge clk);
        rst = 1'b0;
        last_g = 0;
        last_i = 0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_graphs = '0;
        bus.layer_finish = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        batch(1, 1'b0, 1'b0);
        batch(3, 1'b0, 1'b0);
        batch(0, 1'b0, 1'b0);
        batch(2, 1'b1, 1'b0);
        batch(2, 1'b0, 1'b1);
        batch(1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) batch($urandom_range(0, 4), 1'b1, 1'b0);
`ifdef LAYER_TIMEOUT_EN
        timeout_test();
        batch(1, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
